// File: rtl/thermostat_ctrl_pkg.sv
// Shared encodings for the thermostat controller slice.
package thermo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COOL  = 2'd1,
      ST_HEAT  = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      MD_OFF       = 2'd0,
      MD_COOL_ONLY = 2'd1,
      MD_HEAT_ONLY = 2'd2,
      MD_AUTO      = 2'd3
   } mode_t;

   function automatic logic cool_allowed(input logic [1:0] mode);
      return (mode == MD_COOL_ONLY) || (mode == MD_AUTO);
   endfunction

   function automatic logic heat_allowed(input logic [1:0] mode);
      return (mode == MD_HEAT_ONLY) || (mode == MD_AUTO);
   endfunction

endpackage

// File: rtl/thermostat_ctrl_if.sv
// Sensor/config inputs and actuator outputs of the thermostat controller.
interface thermostat_ctrl_if #(parameter int W = 8);

   logic                sample_valid;
   logic signed [W-1:0] sensor;
   logic [1:0]          mode;
   logic signed [W-1:0] cool_on_th;
   logic signed [W-1:0] cool_off_th;
   logic signed [W-1:0] heat_on_th;
   logic signed [W-1:0] heat_off_th;
   logic                cool_o;
   logic                heat_o;
   logic                fault_o;
   logic [1:0]          state_o;

   modport master (
      output sample_valid, sensor, mode,
      output cool_on_th, cool_off_th, heat_on_th, heat_off_th,
      input  cool_o, heat_o, fault_o, state_o
   );

   modport slave (
      input  sample_valid, sensor, mode,
      input  cool_on_th, cool_off_th, heat_on_th, heat_off_th,
      output cool_o, heat_o, fault_o, state_o
   );

endinterface

// File: rtl/thermostat_ctrl_dwell_timer.sv
// Loadable down-counter that sticks at zero; guards minimum on/off times.
module dwell_timer #(
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               i_load,
   input  logic [DWELL_W-1:0] i_load_val,
   output logic               o_zero
);

   logic [DWELL_W-1:0] r_cnt;

   // Load has priority over the saturating decrement.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - DWELL_W'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/thermostat_ctrl.sv
// Hysteresis thermostat: IDLE/COOL/HEAT/FAULT with dwell lockout and
// debounced sensor-plausibility fault handling.
module thermostat_ctrl
   import thermo_pkg::*;
#(
   parameter int W         = 8,
   parameter int DWELL_W   = 16,
   parameter int MIN_ON    = 100,
   parameter int MIN_OFF   = 100,
   parameter int FAULT_LO  = -40,
   parameter int FAULT_HI  = 100,
   parameter int FAULT_CNT = 3
) (
   input  logic               clk,
   input  logic               rstn,
   thermostat_ctrl_if.slave   io_bus
);

   localparam int                  FCW      = (FAULT_CNT < 2) ? 1 : $clog2(FAULT_CNT + 1);
   localparam logic signed [W-1:0] LO_LIM   = W'(FAULT_LO);
   localparam logic signed [W-1:0] HI_LIM   = W'(FAULT_HI);
   localparam logic [FCW-1:0]      FCNT_MAX = FCW'(FAULT_CNT);

   state_t           r_state;
   logic             r_cool;
   logic             r_heat;
   logic             r_fault;
   logic [FCW-1:0]   r_fcnt;

   state_t           w_nxt_state;
   logic             w_impl;
   logic [FCW-1:0]   w_fcnt_inc;
   logic             w_fault_hit;
   logic             w_recover;
   logic             w_dwell_zero;
   logic             w_dwell_load;
   logic [DWELL_W-1:0] w_dwell_val;
   logic             w_cool_en;
   logic             w_heat_en;

   assign w_impl      = (io_bus.sensor < LO_LIM) || (io_bus.sensor > HI_LIM);
   assign w_fcnt_inc  = r_fcnt + FCW'(1);
   assign w_fault_hit = io_bus.sample_valid && w_impl && (r_state != ST_FAULT)
                        && (w_fcnt_inc == FCNT_MAX);
   assign w_recover   = io_bus.sample_valid && !w_impl && (r_state == ST_FAULT)
                        && (w_fcnt_inc == FCNT_MAX);
   assign w_cool_en   = cool_allowed(io_bus.mode);
   assign w_heat_en   = heat_allowed(io_bus.mode);

   // Next-state decision; fault entry outranks every threshold/dwell rule.
   always_comb begin
      w_nxt_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_fault_hit) begin
               w_nxt_state = ST_FAULT;
            end else if (io_bus.sample_valid && w_dwell_zero && w_cool_en
                         && (io_bus.sensor > io_bus.cool_on_th)) begin
               w_nxt_state = ST_COOL;
            end else if (io_bus.sample_valid && w_dwell_zero && w_heat_en
                         && (io_bus.sensor < io_bus.heat_on_th)) begin
               w_nxt_state = ST_HEAT;
            end else begin
               w_nxt_state = ST_IDLE;
            end
         end
         ST_COOL: begin
            if (w_fault_hit) begin
               w_nxt_state = ST_FAULT;
            end else if (!w_cool_en) begin
               w_nxt_state = ST_IDLE;
            end else if (io_bus.sample_valid && w_dwell_zero
                         && (io_bus.sensor < io_bus.cool_off_th)) begin
               w_nxt_state = ST_IDLE;
            end else begin
               w_nxt_state = ST_COOL;
            end
         end
         ST_HEAT: begin
            if (w_fault_hit) begin
               w_nxt_state = ST_FAULT;
            end else if (!w_heat_en) begin
               w_nxt_state = ST_IDLE;
            end else if (io_bus.sample_valid && w_dwell_zero
                         && (io_bus.sensor > io_bus.heat_off_th)) begin
               w_nxt_state = ST_IDLE;
            end else begin
               w_nxt_state = ST_HEAT;
            end
         end
         ST_FAULT: begin
            if (w_recover) begin
               w_nxt_state = ST_IDLE;
            end else begin
               w_nxt_state = ST_FAULT;
            end
         end
         default: begin
            w_nxt_state = ST_IDLE;
         end
      endcase
   end

   // Entering FAULT does not touch the dwell; its exit reloads MIN_OFF.
   assign w_dwell_load = (w_nxt_state != r_state) && (w_nxt_state != ST_FAULT);
   assign w_dwell_val  = (w_nxt_state == ST_IDLE) ? DWELL_W'(MIN_OFF) : DWELL_W'(MIN_ON);

   dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
      .clk        (clk),
      .rstn       (rstn),
      .i_load     (w_dwell_load),
      .i_load_val (w_dwell_val),
      .o_zero     (w_dwell_zero)
   );

   // State, decoded outputs and the plausibility run-length counter.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
         r_cool  <= 1'b0;
         r_heat  <= 1'b0;
         r_fault <= 1'b0;
         r_fcnt  <= '0;
      end else begin
         r_state <= w_nxt_state;
         r_cool  <= (w_nxt_state == ST_COOL);
         r_heat  <= (w_nxt_state == ST_HEAT);
         r_fault <= (w_nxt_state == ST_FAULT);
         if (!io_bus.sample_valid) begin
            r_fcnt <= r_fcnt;
         end else if (w_fault_hit || w_recover) begin
            r_fcnt <= '0;
         end else if ((r_state == ST_FAULT) != w_impl) begin
            r_fcnt <= w_fcnt_inc;
         end else begin
            r_fcnt <= '0;
         end
      end
   end

   assign io_bus.state_o = r_state;
   assign io_bus.cool_o  = r_cool;
   assign io_bus.heat_o  = r_heat;
   assign io_bus.fault_o = r_fault;

endmodule

// File: tb/tb_thermostat_ctrl.sv
// Directed table-driven bench for thermostat_ctrl (MIN_ON=4, MIN_OFF=6).
module tb_thermostat_ctrl;

   localparam logic [1:0] S_I = 2'd0, S_C = 2'd1, S_H = 2'd2, S_F = 2'd3;
   localparam logic [1:0] M_OFF = 2'd0, M_CO = 2'd1, M_HO = 2'd2, M_AU = 2'd3;

   typedef struct {
      logic       v;
      int         sensor;
      logic [1:0] mode;
      logic [1:0] exp_st;
   } vec_t;

   logic clk;
   logic rstn;
   int   checks;
   int   errors;
   vec_t vecs[$];

   thermostat_ctrl_if #(.W(8)) bus_if ();

   thermostat_ctrl #(
      .W(8), .DWELL_W(16), .MIN_ON(4), .MIN_OFF(6),
      .FAULT_LO(-40), .FAULT_HI(100), .FAULT_CNT(3)
   ) dut (
      .clk    (clk),
      .rstn   (rstn),
      .io_bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic v, input int s, input logic [1:0] m,
                      input logic [1:0] e, input int n);
      vec_t t;
      t.v = v; t.sensor = s; t.mode = m; t.exp_st = e;
      for (int k = 0; k < n; k++) vecs.push_back(t);
   endtask

   task automatic check(input string name, input logic [1:0] exp_st);
      logic [4:0] act;
      logic [4:0] want;
      act  = {bus_if.state_o, bus_if.cool_o, bus_if.heat_o, bus_if.fault_o};
      want = {exp_st, exp_st == S_C, exp_st == S_H, exp_st == S_F};
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got state/cool/heat/fault=%b expected %b", name, act, want);
      end
   endtask

   initial begin
      int s8;
      checks = 0;
      errors = 0;
      rstn = 1'b0;
      bus_if.sample_valid = 1'b0;
      bus_if.sensor       = 8'sd0;
      bus_if.mode         = M_OFF;
      bus_if.cool_on_th   = 8'sd35;
      bus_if.cool_off_th  = 8'sd25;
      bus_if.heat_on_th   = 8'sd15;
      bus_if.heat_off_th  = 8'sd30;

      // Cool cycle with dwell, then heat after MIN_OFF lockout.
      add(1'b1,  40, M_AU, S_C, 1);
      add(1'b1,  20, M_AU, S_C, 1);
      add(1'b0,  20, M_AU, S_C, 3);
      add(1'b1,  20, M_AU, S_I, 1);
      add(1'b1,  10, M_AU, S_I, 6);
      add(1'b1,  10, M_AU, S_H, 1);
      add(1'b1,  35, M_AU, S_H, 1);
      add(1'b0,  35, M_AU, S_H, 3);
      add(1'b1,  35, M_AU, S_I, 1);
      // Mode gating and forced exit from HEAT.
      add(1'b1,  10, M_CO, S_I, 1);
      add(1'b0,  10, M_CO, S_I, 5);
      add(1'b1,  10, M_CO, S_I, 1);
      add(1'b1,  10, M_HO, S_H, 1);
      add(1'b0,  10, M_HO, S_H, 1);
      add(1'b0,  10, M_OFF, S_I, 1);
      // Fault entry, interrupted recovery, recovery and lockout.
      add(1'b1, 120, M_AU, S_I, 1);
      add(1'b0, 120, M_AU, S_I, 1);
      add(1'b1, 120, M_AU, S_I, 1);
      add(1'b1, 120, M_AU, S_F, 1);
      add(1'b1,  22, M_AU, S_F, 2);
      add(1'b1, -50, M_AU, S_F, 1);
      add(1'b1,  22, M_AU, S_F, 2);
      add(1'b1,  22, M_AU, S_I, 1);
      add(1'b1,  40, M_AU, S_I, 6);
      add(1'b1,  40, M_AU, S_C, 1);
      // Implausible run broken by a plausible sample while cooling.
      add(1'b1, 110, M_AU, S_C, 2);
      add(1'b1,  20, M_AU, S_C, 1);
      add(1'b1, 120, M_AU, S_C, 1);
      add(1'b1,  20, M_AU, S_I, 1);
      // Strict threshold and plausibility-limit boundaries.
      add(1'b1,  35, M_AU, S_I, 7);
      add(1'b1,  15, M_AU, S_I, 1);
      add(1'b1,  36, M_AU, S_C, 1);
      add(1'b0,  36, M_AU, S_C, 4);
      add(1'b1,  25, M_AU, S_C, 1);
      add(1'b1,  24, M_AU, S_I, 1);
      add(1'b1, 100, M_AU, S_I, 3);
      add(1'b1, -40, M_AU, S_I, 3);
      add(1'b1,  40, M_AU, S_C, 1);
      add(1'b0,  40, M_HO, S_I, 1);
      add(1'b1,  10, M_AU, S_I, 6);
      add(1'b1,  10, M_AU, S_H, 1);

      repeat (2) @(posedge clk);
      #1;
      check("reset", S_I);
      rstn = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         s8 = vecs[i].sensor;
         bus_if.sample_valid = vecs[i].v;
         bus_if.sensor       = s8[7:0];
         bus_if.mode         = vecs[i].mode;
         @(posedge clk);
         #1;
         check($sformatf("row%0d", i), vecs[i].exp_st);
      end

      // Asynchronous reset in HEAT with dwell pending, then immediate start.
      bus_if.sample_valid = 1'b0;
      #2;
      rstn = 1'b0;
      #1;
      check("async_rst", S_I);
      @(posedge clk);
      #1;
      check("rst_hold", S_I);
      rstn = 1'b1;
      bus_if.sample_valid = 1'b1;
      bus_if.sensor       = 8'sd40;
      bus_if.mode         = M_AU;
      @(posedge clk);
      #1;
      check("post_rst_cool", S_C);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
